// File: rtl/vdff_pkg.sv
// rtl/vdff_pkg.sv - shared helpers for the vdff_pipe delay line
// Contents: clog2_min1() width helper, RST_BIT reset data constant.
package vdff_pkg;

  // Reset value of every data bit; replicate to the required width.
  localparam logic RST_BIT = 1'b0;

  // ceil(log2(n)), never less than 1, so a derived port width is never zero.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/vdff_pipe_if.sv
// rtl/vdff_pipe_if.sv - handshake/data bundle for vdff_pipe
// Signals: en, flush, in_valid, in, sel (master drives);
//          out_valid, out, occupancy (slave drives).
interface vdff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2,
  parameter int CNT_W = 3
);
  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in;
  logic [SEL_W-1:0] sel;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] occupancy;

  modport master (
    output en, flush, in_valid, in, sel,
    input  out_valid, out, occupancy
  );

  modport slave (
    input  en, flush, in_valid, in, sel,
    output out_valid, out, occupancy
  );
endinterface

// File: rtl/vdff_stage.sv
// rtl/vdff_stage.sv - one delay stage: data word plus valid bit
// Ports: clk, rst (async, active-high), en (advance), flush (clear valid),
//        next_valid/next_data (from previous stage), valid/data (registered).
module vdff_stage
  import vdff_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             next_valid,
  input  logic [WIDTH-1:0] next_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Flush clears only the valid bit; the stale word stays but is masked
  // at the output by the valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= {WIDTH{RST_BIT}};
    end else if (flush) begin
      valid <= 1'b0;
    end else if (en) begin
      valid <= next_valid;
      data  <= next_data;
    end
  end

endmodule

// File: rtl/vdff_pipe.sv
// rtl/vdff_pipe.sv - DEPTH-stage delay line with valid tracking and tap select
// Ports: clk, rst (async, active-high), bus (vdff_pipe_if.slave):
//        en/flush/in_valid/in/sel in; out_valid/out/occupancy out.
module vdff_pipe
  import vdff_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SEL_W = clog2_min1(DEPTH),
  parameter int CNT_W = clog2_min1(DEPTH + 1)
) (
  input  logic       clk,
  input  logic       rst,
  vdff_pipe_if.slave bus
);

  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic [DEPTH-1:0]            chain_valid;
  logic [DEPTH-1:0][WIDTH-1:0] chain_data;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign chain_valid[k] = bus.in_valid;
      assign chain_data[k]  = bus.in;
    end else begin : g_body
      assign chain_valid[k] = valid[k-1];
      assign chain_data[k]  = data[k-1];
    end

    vdff_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .en         (bus.en),
      .flush      (bus.flush),
      .next_valid (chain_valid[k]),
      .next_data  (chain_data[k]),
      .valid      (valid[k]),
      .data       (data[k])
    );
  end

  // Tap mux: only registered state feeds the output. A sel value with no
  // matching stage leaves the defaults (invalid, zero). DEPTH=1 ignores sel.
  logic             tap_valid;
  logic [WIDTH-1:0] tap_data;

  always_comb begin
    tap_valid = 1'b0;
    tap_data  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (DEPTH == 1 || bus.sel == SEL_W'(k)) begin
        tap_valid = valid[k];
        tap_data  = data[k];
      end
    end
  end

  assign bus.out_valid = tap_valid;
  assign bus.out       = tap_valid ? tap_data : '0;

  // Popcount of the valid bits; tracks flush and stalls by construction.
  logic [CNT_W-1:0] occ;

  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + CNT_W'(valid[k]);
    end
  end

  assign bus.occupancy = occ;

endmodule

// File: tb/tb_vdff_pipe.sv
// tb/tb_vdff_pipe.sv - directed self-checking bench for vdff_pipe
module tb_vdff_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  vdff_pipe_if #(.WIDTH(8), .SEL_W(2), .CNT_W(3)) bus ();
  vdff_pipe_if #(.WIDTH(8), .SEL_W(2), .CNT_W(2)) bus3 ();

  vdff_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vdff_pipe #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic f, input logic v, input logic [7:0] d);
    bus.en       = e;
    bus.flush    = f;
    bus.in_valid = v;
    bus.in       = d;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".data"},  32'(bus.out),       32'(d));
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    bus.sel       = 2'd0;
    bus3.en       = 1'b0;
    bus3.flush    = 1'b0;
    bus3.in_valid = 1'b0;
    bus3.in       = 8'h00;
    bus3.sel      = 2'd0;

    // Reset state
    #1;
    check_out("reset", 1'b0, 8'h00);
    check("reset.occ", 32'(bus.occupancy), 32'd0);
    #16;
    rst = 1'b0;
    tick();

    // Basic latency, sel=2
    bus.sel = 2'd2;
    drive(1'b1, 1'b0, 1'b1, 8'hA1); tick();
    check_out("lat.e1", 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 8'hA2); tick();
    check_out("lat.e2", 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 8'hA3); tick();
    check_out("lat.e3", 1'b1, 8'hA1);
    check("lat.occ3", 32'(bus.occupancy), 32'd3);
    drive(1'b1, 1'b0, 1'b0, 8'h00); tick();
    check_out("lat.e4", 1'b1, 8'hA2);
    check("lat.occ4", 32'(bus.occupancy), 32'd3);
    tick();
    check_out("lat.e5", 1'b1, 8'hA3);
    check("lat.occ5", 32'(bus.occupancy), 32'd2);
    tick();
    check_out("lat.e6", 1'b0, 8'h00);
    check("lat.occ6", 32'(bus.occupancy), 32'd1);
    tick();
    check("lat.occ7", 32'(bus.occupancy), 32'd0);

    // Bubbles and a two-cycle stall, sel=3
    bus.sel = 2'd3;
    drive(1'b1, 1'b0, 1'b1, 8'h11); tick();
    drive(1'b1, 1'b0, 1'b0, 8'h00); tick();
    drive(1'b1, 1'b0, 1'b1, 8'h22); tick();
    check("stall.occ_pre", 32'(bus.occupancy), 32'd2);
    drive(1'b0, 1'b0, 1'b1, 8'hEE); tick();
    check("stall.occ_s1", 32'(bus.occupancy), 32'd2);
    check_out("stall.s1", 1'b0, 8'h00);
    tick();
    check("stall.occ_s2", 32'(bus.occupancy), 32'd2);
    drive(1'b1, 1'b0, 1'b0, 8'h00); tick();
    check_out("stall.w1", 1'b1, 8'h11);
    tick();
    check_out("stall.bub", 1'b0, 8'h00);
    tick();
    check_out("stall.w2", 1'b1, 8'h22);
    tick();
    check_out("stall.tail", 1'b0, 8'h00);
    check("stall.occ_end", 32'(bus.occupancy), 32'd0);

    // Flush colliding with a valid input
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, 1'b1, 8'(8'h30 + k));
      tick();
    end
    check("flush.full", 32'(bus.occupancy), 32'd4);
    drive(1'b1, 1'b1, 1'b1, 8'h55); tick();
    check("flush.occ", 32'(bus.occupancy), 32'd0);
    check_out("flush.out", 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    for (int e = 0; e < 4; e++) begin
      for (int s = 0; s < 4; s++) begin
        bus.sel = 2'(s);
        #1;
        check_out("flush.no55", 1'b0, 8'h00);
      end
      tick();
    end

    // Tap switch 0 -> 3 mid-stream
    bus.sel = 2'd0;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 1'b0, 1'b1, 8'(k));
      tick();
      if (k == 5) begin
        check_out("tap.sel0", 1'b1, 8'd5);
        bus.sel = 2'd3;
        #1;
        check_out("tap.switch", 1'b1, 8'd2);
      end else if (k < 5) begin
        check_out("tap.s0", 1'b1, 8'(k));
      end else begin
        check_out("tap.s3", 1'b1, 8'(k - 3));
      end
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 6; k <= 8; k++) begin
      tick();
      check_out("tap.drain", 1'b1, 8'(k));
    end

    // Async reset mid-stream, sel=1
    drive(1'b1, 1'b1, 1'b0, 8'h00); tick();
    bus.sel = 2'd1;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, 1'b1, 8'(8'h60 + k));
      tick();
    end
    check("arst.occ_pre", 32'(bus.occupancy), 32'd3);
    check_out("arst.pre", 1'b1, 8'h62);
    #2;
    rst = 1'b1;
    #1;
    check_out("arst.now", 1'b0, 8'h00);
    check("arst.occ", 32'(bus.occupancy), 32'd0);
    tick();
    #3;
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 8'h77);
    tick();
    check_out("arst.e1", 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    check_out("arst.e2", 1'b1, 8'h77);

    // Out-of-range tap on the DEPTH=3 build
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      bus3.en       = 1'b1;
      bus3.in_valid = 1'b1;
      bus3.in       = 8'(8'h80 + k);
      tick();
    end
    bus3.en  = 1'b0;
    check("oor.occ", 32'(bus3.occupancy), 32'd3);
    bus3.sel = 2'd2;
    #1;
    check("oor.sel2.valid", 32'(bus3.out_valid), 32'd1);
    check("oor.sel2.data",  32'(bus3.out),       32'h81);
    bus3.sel = 2'd3;
    #1;
    check("oor.sel3.valid", 32'(bus3.out_valid), 32'd0);
    check("oor.sel3.data",  32'(bus3.out),       32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
